// File: rtl/wci_axi_worker_ctl.sv
// wci_axi_worker_ctl
// AXI4-Lite responder terminating a WCI::AXI link at a worker. The upper half
// of the 256-byte window (addr[7]=1) holds control operations, which are issued
// as reads and drive the worker control-state machine. The lower half holds a
// byte-writable property register file that is exported to worker logic.
module wci_axi_worker_ctl #(
   parameter int NREGS = 8
) (
   input  logic                 wciS0_ACLK,
   input  logic                 wciS0_ARESETn,
   input  logic                 wciS0_AWVALID,
   output logic                 wciS0_AWREADY,
   input  logic [31:0]          wciS0_AWADDR,
   input  logic [2:0]           wciS0_AWPROT,
   input  logic                 wciS0_WVALID,
   output logic                 wciS0_WREADY,
   input  logic [31:0]          wciS0_WDATA,
   input  logic [3:0]           wciS0_WSTRB,
   output logic                 wciS0_BVALID,
   input  logic                 wciS0_BREADY,
   output logic [1:0]           wciS0_BRESP,
   input  logic                 wciS0_ARVALID,
   output logic                 wciS0_ARREADY,
   input  logic [31:0]          wciS0_ARADDR,
   input  logic [2:0]           wciS0_ARPROT,
   output logic                 wciS0_RVALID,
   input  logic                 wciS0_RREADY,
   output logic [31:0]          wciS0_RDATA,
   output logic [1:0]           wciS0_RRESP,
   output logic [2:0]           ctl_state,
   output logic                 is_operating,
   output logic [32*NREGS-1:0]  cfg_data
);

   localparam int          IDXW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [5:0]  NREGS_W    = 6'(NREGS);
   localparam logic [31:0] RD_LEGAL   = 32'hC0DE_4201;
   localparam logic [31:0] RD_ILLEGAL = 32'hC0DE_4202;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_EXISTS      = 3'd0,
      ST_INITIALIZED = 3'd1,
      ST_OPERATING   = 3'd2,
      ST_SUSPENDED   = 3'd3,
      ST_UNUSABLE    = 3'd4
   } ctlState_t;

   // Control state machine
   ctlState_t r_state;
   ctlState_t w_stateNext;
   ctlState_t w_opTarget;
   logic      w_ctlLegal;
   logic      w_inService;

   // Ready gating: all channels stay closed until the first edge out of reset
   logic      r_rdyEn;

   // Write channel holding registers and response
   logic        r_awHeld;
   logic [5:0]  r_awAddr;
   logic        r_wHeld;
   logic [31:0] r_wData;
   logic [3:0]  r_wStrb;
   logic        r_bvalid;
   logic [1:0]  r_bresp;

   // Read channel response
   logic        r_rvalid;
   logic [31:0] r_rdata;

   // Property register file
   logic [NREGS-1:0][31:0] r_cfg;

   // Handshake and commit decode
   logic        w_awReady;
   logic        w_wReady;
   logic        w_arReady;
   logic        w_awHs;
   logic        w_wHs;
   logic        w_arHs;
   logic        w_wrCommit;
   logic [5:0]  w_cAddr;
   logic [31:0] w_cData;
   logic [3:0]  w_cStrb;
   logic [4:0]  w_cIdx;
   logic        w_cCtl;
   logic        w_wrIdxOk;
   logic        w_wrAllowed;
   logic        w_cfgWe;
   logic [1:0]  w_bresp;

   // Read decode
   logic [4:0]  w_rdIdx;
   logic        w_rdIdxOk;
   logic [31:0] w_rdData;

   logic        w_unused;

   assign w_unused = ^{wciS0_AWPROT, wciS0_ARPROT,
                       wciS0_AWADDR[31:8], wciS0_AWADDR[1:0],
                       wciS0_ARADDR[31:8], wciS0_ARADDR[1:0]};

   // Property writes and most control ops are only meaningful once initialized
   assign w_inService = (r_state == ST_INITIALIZED) ||
                        (r_state == ST_OPERATING)   ||
                        (r_state == ST_SUSPENDED);

   // A second AW or W cannot be taken while one is held or a response is pending
   assign w_awReady = r_rdyEn & ~r_awHeld & ~r_bvalid;
   assign w_wReady  = r_rdyEn & ~r_wHeld  & ~r_bvalid;
   assign w_arReady = r_rdyEn & ~r_rvalid;

   assign w_awHs = wciS0_AWVALID & w_awReady;
   assign w_wHs  = wciS0_WVALID  & w_wReady;
   assign w_arHs = wciS0_ARVALID & w_arReady;

   // Write commit: combine held and freshly arriving halves, then classify the access
   always_comb begin
      w_wrCommit  = (r_awHeld | w_awHs) & (r_wHeld | w_wHs);
      w_cAddr     = r_awHeld ? r_awAddr : wciS0_AWADDR[7:2];
      w_cData     = r_wHeld  ? r_wData  : wciS0_WDATA;
      w_cStrb     = r_wHeld  ? r_wStrb  : wciS0_WSTRB;
      w_cCtl      = w_cAddr[5];
      w_cIdx      = w_cAddr[4:0];
      w_wrIdxOk   = ({1'b0, w_cIdx} < NREGS_W);
      w_wrAllowed = ~w_cCtl & w_inService;
      w_cfgWe     = w_wrCommit & w_wrAllowed & w_wrIdxOk;
      w_bresp     = w_wrAllowed ? RESP_OKAY : RESP_SLVERR;
   end

   // Control-op legality and the state each op leads to from the current state
   always_comb begin
      w_ctlLegal = 1'b0;
      w_opTarget = r_state;
      case (wciS0_ARADDR[4:2])
         3'd0: begin
            w_ctlLegal = (r_state == ST_EXISTS);
            w_opTarget = ST_INITIALIZED;
         end
         3'd1: begin
            w_ctlLegal = (r_state == ST_INITIALIZED) || (r_state == ST_SUSPENDED);
            w_opTarget = ST_OPERATING;
         end
         3'd2: begin
            w_ctlLegal = (r_state == ST_OPERATING);
            w_opTarget = ST_SUSPENDED;
         end
         3'd3: begin
            w_ctlLegal = w_inService;
            w_opTarget = ST_UNUSABLE;
         end
         3'd4, 3'd5, 3'd6: begin
            w_ctlLegal = w_inService;
            w_opTarget = r_state;
         end
         default: begin
            w_ctlLegal = 1'b0;
            w_opTarget = r_state;
         end
      endcase
      w_stateNext = (w_arHs && wciS0_ARADDR[7] && w_ctlLegal) ? w_opTarget : r_state;
   end

   // Read data: control ops report legality, property reads return the register
   always_comb begin
      w_rdIdx   = wciS0_ARADDR[6:2];
      w_rdIdxOk = ({1'b0, w_rdIdx} < NREGS_W);
      w_rdData  = '0;
      if (wciS0_ARADDR[7]) begin
         w_rdData = w_ctlLegal ? RD_LEGAL : RD_ILLEGAL;
      end else if (w_rdIdxOk) begin
         w_rdData = r_cfg[w_rdIdx[IDXW-1:0]];
      end
   end

   // Control state register
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_state <= ST_EXISTS;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Open the ready lines one edge after reset is released
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_rdyEn <= 1'b0;
      end else begin
         r_rdyEn <= 1'b1;
      end
   end

   // AW/W holding registers: capture each half independently, drain on commit
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_awHeld <= 1'b0;
         r_awAddr <= '0;
         r_wHeld  <= 1'b0;
         r_wData  <= '0;
         r_wStrb  <= '0;
      end else if (w_wrCommit) begin
         r_awHeld <= 1'b0;
         r_wHeld  <= 1'b0;
      end else begin
         if (w_awHs) begin
            r_awHeld <= 1'b1;
            r_awAddr <= wciS0_AWADDR[7:2];
         end
         if (w_wHs) begin
            r_wHeld <= 1'b1;
            r_wData <= wciS0_WDATA;
            r_wStrb <= wciS0_WSTRB;
         end
      end
   end

   // Write response: raised with the commit, held until BREADY is seen
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_wrCommit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_bresp;
      end else if (r_bvalid && wciS0_BREADY) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read response: one outstanding read, data frozen until RREADY is seen
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_arHs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rdData;
      end else if (r_rvalid && wciS0_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   // Property register file with per-byte write enables
   always_ff @(posedge wciS0_ACLK or negedge wciS0_ARESETn) begin
      if (!wciS0_ARESETn) begin
         r_cfg <= '0;
      end else if (w_cfgWe) begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_cIdx == 5'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_cStrb[b]) begin
                     r_cfg[i][8*b +: 8] <= w_cData[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign wciS0_AWREADY = w_awReady;
   assign wciS0_WREADY  = w_wReady;
   assign wciS0_ARREADY = w_arReady;
   assign wciS0_BVALID  = r_bvalid;
   assign wciS0_BRESP   = r_bresp;
   assign wciS0_RVALID  = r_rvalid;
   assign wciS0_RDATA   = r_rdata;
   assign wciS0_RRESP   = RESP_OKAY;
   assign ctl_state     = r_state;
   assign is_operating  = (r_state == ST_OPERATING);
   assign cfg_data      = r_cfg;

endmodule

// File: tb/tb_wci_axi_worker_ctl.sv
// Directed testbench for wci_axi_worker_ctl: control lifecycle, property
// access, write-channel skew, back-pressure and asynchronous reset.
module tb_wci_axi_worker_ctl;

   localparam int NREGS = 8;

   logic               wciS0_ACLK;
   logic               wciS0_ARESETn;
   logic               wciS0_AWVALID;
   logic               wciS0_AWREADY;
   logic [31:0]        wciS0_AWADDR;
   logic [2:0]         wciS0_AWPROT;
   logic               wciS0_WVALID;
   logic               wciS0_WREADY;
   logic [31:0]        wciS0_WDATA;
   logic [3:0]         wciS0_WSTRB;
   logic               wciS0_BVALID;
   logic               wciS0_BREADY;
   logic [1:0]         wciS0_BRESP;
   logic               wciS0_ARVALID;
   logic               wciS0_ARREADY;
   logic [31:0]        wciS0_ARADDR;
   logic [2:0]         wciS0_ARPROT;
   logic               wciS0_RVALID;
   logic               wciS0_RREADY;
   logic [31:0]        wciS0_RDATA;
   logic [1:0]         wciS0_RRESP;
   logic [2:0]         ctl_state;
   logic               is_operating;
   logic [32*NREGS-1:0] cfg_data;

   int errors = 0;
   int checks = 0;

   wci_axi_worker_ctl #(.NREGS(NREGS)) dut (
      .wciS0_ACLK    (wciS0_ACLK),
      .wciS0_ARESETn (wciS0_ARESETn),
      .wciS0_AWVALID (wciS0_AWVALID),
      .wciS0_AWREADY (wciS0_AWREADY),
      .wciS0_AWADDR  (wciS0_AWADDR),
      .wciS0_AWPROT  (wciS0_AWPROT),
      .wciS0_WVALID  (wciS0_WVALID),
      .wciS0_WREADY  (wciS0_WREADY),
      .wciS0_WDATA   (wciS0_WDATA),
      .wciS0_WSTRB   (wciS0_WSTRB),
      .wciS0_BVALID  (wciS0_BVALID),
      .wciS0_BREADY  (wciS0_BREADY),
      .wciS0_BRESP   (wciS0_BRESP),
      .wciS0_ARVALID (wciS0_ARVALID),
      .wciS0_ARREADY (wciS0_ARREADY),
      .wciS0_ARADDR  (wciS0_ARADDR),
      .wciS0_ARPROT  (wciS0_ARPROT),
      .wciS0_RVALID  (wciS0_RVALID),
      .wciS0_RREADY  (wciS0_RREADY),
      .wciS0_RDATA   (wciS0_RDATA),
      .wciS0_RRESP   (wciS0_RRESP),
      .ctl_state     (ctl_state),
      .is_operating  (is_operating),
      .cfg_data      (cfg_data)
   );

   // 100 MHz clock
   initial begin
      wciS0_ACLK = 1'b0;
      forever #5 wciS0_ACLK = ~wciS0_ACLK;
   end

   // Advance to just after the next rising edge
   task automatic nextCycle();
      @(posedge wciS0_ACLK);
      #1;
   endtask

   // Single read: wait for ARREADY, hand over the address, collect the response
   task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      wciS0_ARADDR  = addr;
      wciS0_ARVALID = 1'b1;
      n = 0;
      while (!wciS0_ARREADY && n < 20) begin
         nextCycle();
         n++;
      end
      nextCycle();
      wciS0_ARVALID = 1'b0;
      n = 0;
      while (!wciS0_RVALID && n < 20) begin
         nextCycle();
         n++;
      end
      if (!wciS0_RVALID) begin
         checks++;
         errors++;
         $display("[TB] FAIL read_timeout addr=%h: RVALID got 0 expected 1", addr);
      end
      data = wciS0_RDATA;
      resp = wciS0_RRESP;
      nextCycle();
   endtask

   // Single write with AW and W presented together; either may be taken first
   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
      int n;
      logic awGo, wGo;
      wciS0_AWADDR  = addr;
      wciS0_WDATA   = data;
      wciS0_WSTRB   = strb;
      wciS0_AWVALID = 1'b1;
      wciS0_WVALID  = 1'b1;
      n = 0;
      while ((wciS0_AWVALID || wciS0_WVALID) && n < 20) begin
         awGo = wciS0_AWVALID && wciS0_AWREADY;
         wGo  = wciS0_WVALID && wciS0_WREADY;
         nextCycle();
         if (awGo) wciS0_AWVALID = 1'b0;
         if (wGo)  wciS0_WVALID  = 1'b0;
         n++;
      end
      wciS0_AWVALID = 1'b0;
      wciS0_WVALID  = 1'b0;
      n = 0;
      while (!wciS0_BVALID && n < 20) begin
         nextCycle();
         n++;
      end
      if (!wciS0_BVALID) begin
         checks++;
         errors++;
         $display("[TB] FAIL write_timeout addr=%h: BVALID got 0 expected 1", addr);
      end
      resp = wciS0_BRESP;
      nextCycle();
   endtask

   // Reset values while held in reset and the ready opening after release
   task automatic test_reset();
      wciS0_ARESETn = 1'b0;
      wciS0_AWVALID = 1'b0; wciS0_AWADDR = '0; wciS0_AWPROT = '0;
      wciS0_WVALID  = 1'b0; wciS0_WDATA  = '0; wciS0_WSTRB  = '0;
      wciS0_ARVALID = 1'b0; wciS0_ARADDR = '0; wciS0_ARPROT = '0;
      wciS0_BREADY  = 1'b1; wciS0_RREADY = 1'b1;
      repeat (3) nextCycle();
      checks++; if ({wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY} !== 3'b000) begin errors++;
         $display("[TB] FAIL reset_ready: got %b expected 000", {wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY}); end
      checks++; if ({wciS0_BVALID, wciS0_RVALID, wciS0_BRESP, wciS0_RRESP} !== 6'b0) begin errors++;
         $display("[TB] FAIL reset_resp: got %b expected 0", {wciS0_BVALID, wciS0_RVALID, wciS0_BRESP, wciS0_RRESP}); end
      checks++; if (wciS0_RDATA !== 32'h0) begin errors++;
         $display("[TB] FAIL reset_rdata: got %h expected 0", wciS0_RDATA); end
      checks++; if ({ctl_state, is_operating} !== 4'b0000) begin errors++;
         $display("[TB] FAIL reset_state: got %b expected 0000", {ctl_state, is_operating}); end
      checks++; if (cfg_data !== '0) begin errors++;
         $display("[TB] FAIL reset_cfg: got %h expected 0", cfg_data); end
      @(negedge wciS0_ACLK);
      wciS0_ARESETn = 1'b1;
      #1;
      checks++; if ({wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY} !== 3'b000) begin errors++;
         $display("[TB] FAIL ready_before_edge: got %b expected 000", {wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY}); end
      nextCycle();
      checks++; if ({wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY} !== 3'b111) begin errors++;
         $display("[TB] FAIL ready_after_edge: got %b expected 111", {wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY}); end
   endtask

   // Property write in Exists is rejected
   task automatic test_exists_write();
      logic [1:0] resp;
      axiWrite(32'h4, 32'hDEAD_BEEF, 4'hF, resp);
      checks++; if (resp !== 2'b10) begin errors++;
         $display("[TB] FAIL exists_write_bresp: got %b expected 10", resp); end
      checks++; if (cfg_data[63:32] !== 32'h0) begin errors++;
         $display("[TB] FAIL exists_write_reg1: got %h expected 0", cfg_data[63:32]); end
   endtask

   // initialize is legal once, then illegal
   task automatic test_ctl_init();
      logic [31:0] data;
      logic [1:0]  resp;
      axiRead(32'h80, data, resp);
      checks++; if ({data, resp} !== {32'hC0DE_4201, 2'b00}) begin errors++;
         $display("[TB] FAIL init_rdata: got %h/%b expected c0de4201/00", data, resp); end
      checks++; if (ctl_state !== 3'd1) begin errors++;
         $display("[TB] FAIL init_state: got %0d expected 1", ctl_state); end
      axiRead(32'h80, data, resp);
      checks++; if ({data, resp} !== {32'hC0DE_4202, 2'b00}) begin errors++;
         $display("[TB] FAIL reinit_rdata: got %h/%b expected c0de4202/00", data, resp); end
      checks++; if (ctl_state !== 3'd1) begin errors++;
         $display("[TB] FAIL reinit_state: got %0d expected 1", ctl_state); end
   endtask

   // Property write/read, out-of-range index and control-space write
   task automatic test_property_rw();
      logic [31:0] data;
      logic [1:0]  resp;
      axiWrite(32'h4, 32'hDEAD_BEEF, 4'hF, resp);
      checks++; if (resp !== 2'b00) begin errors++;
         $display("[TB] FAIL prop_write_bresp: got %b expected 00", resp); end
      checks++; if (cfg_data[63:32] !== 32'hDEAD_BEEF) begin errors++;
         $display("[TB] FAIL prop_write_reg1: got %h expected deadbeef", cfg_data[63:32]); end
      axiRead(32'h4, data, resp);
      checks++; if ({data, resp} !== {32'hDEAD_BEEF, 2'b00}) begin errors++;
         $display("[TB] FAIL prop_read_reg1: got %h/%b expected deadbeef/00", data, resp); end
      axiWrite(32'h28, 32'h1111_1111, 4'hF, resp);
      checks++; if (resp !== 2'b00) begin errors++;
         $display("[TB] FAIL oob_write_bresp: got %b expected 00", resp); end
      checks++; if (cfg_data !== {192'h0, 32'hDEAD_BEEF, 32'h0}) begin errors++;
         $display("[TB] FAIL oob_write_cfg: got %h expected reg1 only", cfg_data); end
      axiRead(32'h28, data, resp);
      checks++; if ({data, resp} !== {32'h0, 2'b00}) begin errors++;
         $display("[TB] FAIL oob_read: got %h/%b expected 0/00", data, resp); end
      axiWrite(32'h84, 32'h0, 4'hF, resp);
      checks++; if (resp !== 2'b10) begin errors++;
         $display("[TB] FAIL ctl_write_bresp: got %b expected 10", resp); end
      checks++; if (ctl_state !== 3'd1) begin errors++;
         $display("[TB] FAIL ctl_write_state: got %0d expected 1", ctl_state); end
   endtask

   // Byte strobes with W arriving three cycles ahead of AW
   task automatic test_strobe_early_w();
      wciS0_WDATA  = 32'hFFFF_FFFF;
      wciS0_WSTRB  = 4'b0101;
      wciS0_WVALID = 1'b1;
      nextCycle();
      wciS0_WVALID = 1'b0;
      checks++; if (wciS0_WREADY !== 1'b0) begin errors++;
         $display("[TB] FAIL wready_held: got %b expected 0", wciS0_WREADY); end
      nextCycle();
      nextCycle();
      checks++; if (wciS0_BVALID !== 1'b0) begin errors++;
         $display("[TB] FAIL bvalid_early: got %b expected 0", wciS0_BVALID); end
      wciS0_AWADDR  = 32'h0;
      wciS0_AWVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      checks++; if ({wciS0_BVALID, wciS0_BRESP} !== 3'b100) begin errors++;
         $display("[TB] FAIL skew_bvalid: got %b expected 100", {wciS0_BVALID, wciS0_BRESP}); end
      checks++; if (cfg_data[31:0] !== 32'h00FF_00FF) begin errors++;
         $display("[TB] FAIL strobe_reg0: got %h expected 00ff00ff", cfg_data[31:0]); end
      nextCycle();
   endtask

   // Back-pressure on both response channels with a write and read in flight
   task automatic test_stall();
      int bad;
      wciS0_BREADY  = 1'b0;
      wciS0_RREADY  = 1'b0;
      wciS0_AWADDR  = 32'h8;
      wciS0_WDATA   = 32'h1234_5678;
      wciS0_WSTRB   = 4'hF;
      wciS0_ARADDR  = 32'h4;
      wciS0_AWVALID = 1'b1;
      wciS0_WVALID  = 1'b1;
      wciS0_ARVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      wciS0_WVALID  = 1'b0;
      wciS0_ARVALID = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ({wciS0_BVALID, wciS0_BRESP, wciS0_RVALID, wciS0_RDATA, wciS0_RRESP} !==
             {1'b1, 2'b00, 1'b1, 32'hDEAD_BEEF, 2'b00}) bad++;
         if ({wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY} !== 3'b000) bad++;
         nextCycle();
      end
      checks++; if (bad !== 0) begin errors++;
         $display("[TB] FAIL stall_stable: got %0d bad cycles expected 0", bad); end
      checks++; if (cfg_data[95:64] !== 32'h1234_5678) begin errors++;
         $display("[TB] FAIL stall_reg2: got %h expected 12345678", cfg_data[95:64]); end
      wciS0_BREADY = 1'b1;
      wciS0_RREADY = 1'b1;
      nextCycle();
      checks++; if ({wciS0_BVALID, wciS0_RVALID, wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY} !== 5'b00111) begin errors++;
         $display("[TB] FAIL stall_release: got %b expected 00111",
                  {wciS0_BVALID, wciS0_RVALID, wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY}); end
   endtask

   // Full control lifecycle, including a write racing the release op
   task automatic test_lifecycle();
      logic [31:0] data;
      logic [1:0]  resp;
      axiRead(32'h84, data, resp);
      checks++; if ({data, ctl_state, is_operating} !== {32'hC0DE_4201, 3'd2, 1'b1}) begin errors++;
         $display("[TB] FAIL start1: got %h/%0d/%b expected c0de4201/2/1", data, ctl_state, is_operating); end
      axiRead(32'h88, data, resp);
      checks++; if ({data, ctl_state, is_operating} !== {32'hC0DE_4201, 3'd3, 1'b0}) begin errors++;
         $display("[TB] FAIL stop: got %h/%0d/%b expected c0de4201/3/0", data, ctl_state, is_operating); end
      axiRead(32'h9C, data, resp);
      checks++; if ({data, ctl_state} !== {32'hC0DE_4202, 3'd3}) begin errors++;
         $display("[TB] FAIL op7: got %h/%0d expected c0de4202/3", data, ctl_state); end
      axiRead(32'h90, data, resp);
      checks++; if ({data, ctl_state} !== {32'hC0DE_4201, 3'd3}) begin errors++;
         $display("[TB] FAIL op_test: got %h/%0d expected c0de4201/3", data, ctl_state); end
      axiRead(32'h84, data, resp);
      checks++; if ({data, ctl_state, is_operating} !== {32'hC0DE_4201, 3'd2, 1'b1}) begin errors++;
         $display("[TB] FAIL start2: got %h/%0d/%b expected c0de4201/2/1", data, ctl_state, is_operating); end
      wciS0_AWADDR  = 32'hC;
      wciS0_WDATA   = 32'hA5A5_A5A5;
      wciS0_WSTRB   = 4'hF;
      wciS0_ARADDR  = 32'h8C;
      wciS0_AWVALID = 1'b1;
      wciS0_WVALID  = 1'b1;
      wciS0_ARVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      wciS0_WVALID  = 1'b0;
      wciS0_ARVALID = 1'b0;
      checks++; if ({wciS0_BVALID, wciS0_BRESP, wciS0_RVALID, wciS0_RDATA} !== {1'b1, 2'b00, 1'b1, 32'hC0DE_4201}) begin errors++;
         $display("[TB] FAIL release_race_resp: got %b/%b/%b/%h expected 1/00/1/c0de4201",
                  wciS0_BVALID, wciS0_BRESP, wciS0_RVALID, wciS0_RDATA); end
      checks++; if ({ctl_state, is_operating, cfg_data[127:96]} !== {3'd4, 1'b0, 32'hA5A5_A5A5}) begin errors++;
         $display("[TB] FAIL release_race_state: got %0d/%b/%h expected 4/0/a5a5a5a5",
                  ctl_state, is_operating, cfg_data[127:96]); end
      nextCycle();
      axiWrite(32'hC, 32'h0, 4'hF, resp);
      checks++; if ({resp, cfg_data[127:96]} !== {2'b10, 32'hA5A5_A5A5}) begin errors++;
         $display("[TB] FAIL unusable_write: got %b/%h expected 10/a5a5a5a5", resp, cfg_data[127:96]); end
      axiRead(32'h84, data, resp);
      checks++; if ({data, ctl_state} !== {32'hC0DE_4202, 3'd4}) begin errors++;
         $display("[TB] FAIL unusable_start: got %h/%0d expected c0de4202/4", data, ctl_state); end
   endtask

   // Asynchronous reset with an AW held and no W: the half-write must vanish
   task automatic test_reset_mid_write();
      int sawB;
      wciS0_AWADDR  = 32'h8;
      wciS0_AWVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      checks++; if (wciS0_AWREADY !== 1'b0) begin errors++;
         $display("[TB] FAIL aw_held: got %b expected 0", wciS0_AWREADY); end
      #2;
      wciS0_ARESETn = 1'b0;
      #1;
      checks++; if ({wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY, wciS0_BVALID, wciS0_RVALID} !== 5'b0) begin errors++;
         $display("[TB] FAIL midreset_flags: got %b expected 00000",
                  {wciS0_AWREADY, wciS0_WREADY, wciS0_ARREADY, wciS0_BVALID, wciS0_RVALID}); end
      checks++; if ({ctl_state, cfg_data} !== '0) begin errors++;
         $display("[TB] FAIL midreset_state: state %0d cfg %h expected 0", ctl_state, cfg_data); end
      @(negedge wciS0_ACLK);
      @(negedge wciS0_ACLK);
      wciS0_ARESETn = 1'b1;
      nextCycle();
      wciS0_WDATA  = 32'h5555_5555;
      wciS0_WSTRB  = 4'hF;
      wciS0_WVALID = 1'b1;
      nextCycle();
      wciS0_WVALID = 1'b0;
      sawB = 0;
      for (int i = 0; i < 4; i++) begin
         if (wciS0_BVALID !== 1'b0) sawB++;
         nextCycle();
      end
      checks++; if (sawB !== 0) begin errors++;
         $display("[TB] FAIL stale_bvalid: got %0d cycles with BVALID expected 0", sawB); end
      wciS0_AWADDR  = 32'hC;
      wciS0_AWVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      checks++; if ({wciS0_BVALID, wciS0_BRESP} !== 3'b110) begin errors++;
         $display("[TB] FAIL post_reset_write: got %b expected 110", {wciS0_BVALID, wciS0_BRESP}); end
      nextCycle();
   endtask

   // Write and initialize in the same cycle: write judged against Exists
   task automatic test_back_to_back();
      wciS0_AWADDR  = 32'hC;
      wciS0_WDATA   = 32'h7777_7777;
      wciS0_WSTRB   = 4'hF;
      wciS0_ARADDR  = 32'h80;
      wciS0_AWVALID = 1'b1;
      wciS0_WVALID  = 1'b1;
      wciS0_ARVALID = 1'b1;
      nextCycle();
      wciS0_AWVALID = 1'b0;
      wciS0_WVALID  = 1'b0;
      wciS0_ARVALID = 1'b0;
      checks++; if ({wciS0_BVALID, wciS0_BRESP, wciS0_RVALID, wciS0_RDATA} !== {1'b1, 2'b10, 1'b1, 32'hC0DE_4201}) begin errors++;
         $display("[TB] FAIL same_cycle_resp: got %b/%b/%b/%h expected 1/10/1/c0de4201",
                  wciS0_BVALID, wciS0_BRESP, wciS0_RVALID, wciS0_RDATA); end
      checks++; if ({ctl_state, cfg_data[127:96]} !== {3'd1, 32'h0}) begin errors++;
         $display("[TB] FAIL same_cycle_state: got %0d/%h expected 1/0", ctl_state, cfg_data[127:96]); end
      nextCycle();
   endtask

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence
   initial begin
      test_reset();
      test_exists_write();
      test_ctl_init();
      test_property_rw();
      test_strobe_early_w();
      test_stall();
      test_lifecycle();
      test_reset_mid_write();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
